// File: rtl/led_pkg.sv
// Shared constants for the LED scan controller: scan rate default, FSM encodings,
// digit count, seven-segment code table and the double-dabble adjust step.
package led_pkg;

  localparam int SCAN_DIV_DEF = 100000;
  localparam int NUM_DIGITS   = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CONV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Segments {G,F,E,D,C,B,A}; DP is appended by the decoder.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [39:0] dd_adjust(input logic [39:0] b);
    logic [39:0] r;
    for (int i = 0; i < 10; i++)
      r[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    return r;
  endfunction

endpackage

// File: rtl/led_seg_decode.sv
// BCD digit to seven-segment pattern with blanking and a separate decimal point.
module led_seg_decode
  import led_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [6:0] w_code;

  assign w_code = seg_code(i_digit);
  assign o_seg  = {i_dp, i_blank ? 7'h00 : w_code};

endmodule

// File: rtl/led_scan_ctrl.sv
// Binary-to-BCD converter feeding two multiplexed 4-digit seven-segment displays;
// a new value is converted serially while the previous one keeps being scanned.
module led_scan_ctrl
  import led_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        num_valid,
  input  logic [31:0] num,
  output logic        num_ready,
  input  logic        lz_blank,
  output logic        ovf,
  output logic [7:0]  seg0,
  output logic [3:0]  an0,
  output logic [7:0]  seg1,
  output logic [3:0]  an1
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [1:0]    r_state;
  logic          r_ready;
  logic [31:0]   r_bin;
  logic [39:0]   r_bcd;
  logic [4:0]    r_step;
  logic [31:0]   r_disp;
  logic          r_ovf;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [7:0]    r_seg0, r_seg1;
  logic [3:0]    r_an0, r_an1;

  logic [39:0]   w_bcd_adj;
  logic [2:0]    w_msd;
  logic [2:0]    w_pos_lo, w_pos_hi;
  logic [3:0]    w_dig_lo, w_dig_hi;
  logic          w_blank_lo, w_blank_hi, w_dp_hi;
  logic [7:0]    w_seg_lo, w_seg_hi;

  assign w_bcd_adj = dd_adjust(r_bcd);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain the shift through in one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ready <= 1'b0;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_step  <= '0;
      // NOTE: the display register is a handful of flops, not a RAM, so it is
      // reset; this is also what guarantees no partial commit survives a reset.
      r_disp  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ready <= 1'b1;
          if (num_valid && r_ready) begin
            r_bin   <= num;
            r_bcd   <= '0;
            r_step  <= '0;
            r_ready <= 1'b0;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          {r_bcd, r_bin} <= {w_bcd_adj[38:0], r_bin, 1'b0};
          r_step         <= r_step + 5'd1;
          if (r_step == 5'd31) r_state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          r_disp  <= r_bcd[31:0];
          r_ovf   <= |r_bcd[39:32];
          r_ready <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // NOTE: give every always_comb output a default before any conditional
  // assignment, otherwise synthesis infers a latch.
  always_comb begin
    w_msd = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++)
      if (r_disp[4*i +: 4] != 4'd0) w_msd = 3'(i);
  end

  assign w_pos_lo   = {1'b0, r_idx};
  assign w_pos_hi   = {1'b1, r_idx};
  assign w_dig_lo   = r_disp[{w_pos_lo, 2'b00} +: 4];
  assign w_dig_hi   = r_disp[{w_pos_hi, 2'b00} +: 4];
  assign w_blank_lo = lz_blank && (w_pos_lo > w_msd);
  assign w_blank_hi = lz_blank && (w_pos_hi > w_msd);
  // DP on the top digit flags that the upper decimal digits were truncated.
  assign w_dp_hi    = r_ovf && (r_idx == 2'd3);

  led_seg_decode u_dec_lo (
    .i_digit (w_dig_lo),
    .i_blank (w_blank_lo),
    .i_dp    (1'b0),
    .o_seg   (w_seg_lo)
  );

  led_seg_decode u_dec_hi (
    .i_digit (w_dig_hi),
    .i_blank (w_blank_hi),
    .i_dp    (w_dp_hi),
    .o_seg   (w_seg_hi)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_seg0  <= 8'h00;
      r_seg1  <= 8'h00;
      r_an0   <= 4'b0000;
      r_an1   <= 4'b0000;
    end else begin
      if (r_presc == PW'(SCAN_DIV - 1)) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
      end else begin
        r_presc <= r_presc + PW'(1);
      end
      r_an0  <= 4'b0001 << r_idx;
      r_an1  <= 4'b0001 << r_idx;
      r_seg0 <= w_seg_lo;
      r_seg1 <= w_seg_hi;
    end
  end

  assign num_ready = r_ready;
  assign ovf       = r_ovf;
  assign seg0      = r_seg0;
  assign seg1      = r_seg1;
  assign an0       = r_an0;
  assign an1       = r_an1;

endmodule
